// File: rtl/axis_pattern_gen_if.sv
// AXI-stream bundle shared by the pattern source and whatever consumes it.
// The master drives payload and tvalid; the slave drives tready.
interface axi_stream_inf #(
  parameter int DSIZE = 16,
  parameter int USIZE = 1
);
  logic             tvalid;
  logic             tready;
  logic [DSIZE-1:0] tdata;
  logic             tlast;
  logic [USIZE-1:0] tuser;

  modport master (output tvalid, tdata, tlast, tuser, input tready);
  modport slave  (input tvalid, tdata, tlast, tuser, output tready);
endinterface

// File: rtl/axis_pattern_gen.sv
// AXI-stream test-pattern source: framed packets of incrementing, PRBS32, constant
// or walking-one data, with configurable length, gap and packet count.
module axis_pattern_gen #(
  parameter int DSIZE = 16,
  parameter int LSIZE = 16,
  parameter int GSIZE = 8,
  parameter int CSIZE = 16
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              enable,
  input  logic [1:0]        mode,
  input  logic [DSIZE-1:0]  seed,
  input  logic [LSIZE-1:0]  pkt_len,
  input  logic [GSIZE-1:0]  pkt_gap,
  input  logic [CSIZE-1:0]  pkt_num,
  output logic              busy,
  output logic              done,
  output logic [CSIZE-1:0]  pkts_sent,
  axi_stream_inf.master     origin_inf
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  localparam logic [1:0] M_INCR = 2'd0;
  localparam logic [1:0] M_PRBS = 2'd1;
  localparam logic [1:0] M_CONST = 2'd2;
  localparam logic [1:0] M_WALK = 2'd3;

  state_t           state;
  logic [1:0]       mode_q;
  logic [DSIZE-1:0] seed_q;
  logic [LSIZE-1:0] len_q;
  logic [GSIZE-1:0] gap_q;
  logic [CSIZE-1:0] num_q;
  logic [LSIZE-1:0] beat_cnt;
  logic [GSIZE-1:0] gap_cnt;
  logic [31:0]      lfsr;
  logic             tvalid;
  logic [DSIZE-1:0] tdata;
  logic             tlast;
  logic             tuser;

  // Seed is tiled across the 32-bit LFSR; a zero state would lock up, so force it to 1.
  function automatic logic [31:0] seed_to_lfsr(input logic [DSIZE-1:0] s);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = s[i % DSIZE];
    if (r == 32'd0) r = 32'd1;
    return r;
  endfunction

  function automatic logic [DSIZE-1:0] lfsr_to_word(input logic [31:0] s);
    logic [DSIZE-1:0] w;
    for (int i = 0; i < DSIZE; i++) w[i] = s[i % 32];
    return w;
  endfunction

  // Right-shifting Galois form of x^32+x^22+x^2+x+1.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  function automatic logic [DSIZE-1:0] first_word(input logic [1:0] m,
                                                  input logic [DSIZE-1:0] s,
                                                  input logic [31:0] l);
    case (m)
      M_PRBS:  return lfsr_to_word(l);
      M_WALK:  return {{(DSIZE-1){1'b0}}, 1'b1};
      default: return s;
    endcase
  endfunction

  function automatic logic [DSIZE-1:0] next_word(input logic [1:0] m,
                                                 input logic [DSIZE-1:0] cur,
                                                 input logic [DSIZE-1:0] s,
                                                 input logic [31:0] l_next);
    case (m)
      M_INCR:  return cur + 1'b1;
      M_PRBS:  return lfsr_to_word(l_next);
      M_CONST: return s;
      default: return {cur[DSIZE-2:0], cur[DSIZE-1]};
    endcase
  endfunction

  logic [31:0]      lfsr_init;
  logic [31:0]      lfsr_next;
  logic [LSIZE-1:0] len_eff;
  logic             beat;
  logic             run_complete;

  assign lfsr_init    = seed_to_lfsr(seed);
  assign lfsr_next    = lfsr_step(lfsr);
  assign len_eff      = (pkt_len == '0) ? LSIZE'(1) : pkt_len;
  assign beat         = tvalid & origin_inf.tready;
  assign run_complete = (num_q != '0) && (CSIZE'(pkts_sent + 1'b1) == num_q);

  always_ff @(posedge clock) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pkts_sent <= '0;
      tvalid    <= 1'b0;
      tdata     <= '0;
      tlast     <= 1'b0;
      tuser     <= 1'b0;
      mode_q    <= '0;
      seed_q    <= '0;
      len_q     <= LSIZE'(1);
      gap_q     <= '0;
      num_q     <= '0;
      beat_cnt  <= '0;
      gap_cnt   <= '0;
      lfsr      <= 32'd1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state     <= SEND;
            busy      <= 1'b1;
            mode_q    <= mode;
            seed_q    <= seed;
            len_q     <= len_eff;
            gap_q     <= pkt_gap;
            num_q     <= pkt_num;
            pkts_sent <= '0;
            beat_cnt  <= '0;
            lfsr      <= lfsr_init;
            tdata     <= first_word(mode, seed, lfsr_init);
            tvalid    <= 1'b1;
            tuser     <= 1'b1;
            tlast     <= (len_eff == LSIZE'(1));
          end
        end
        SEND: begin
          if (beat) begin
            lfsr  <= lfsr_next;
            tdata <= next_word(mode_q, tdata, seed_q, lfsr_next);
            if (tlast) begin
              pkts_sent <= pkts_sent + 1'b1;
              beat_cnt  <= '0;
              if (run_complete || !enable) begin
                state  <= IDLE;
                busy   <= 1'b0;
                done   <= run_complete;
                tvalid <= 1'b0;
                tlast  <= 1'b0;
                tuser  <= 1'b0;
              end else if (gap_q == '0) begin
                tuser <= 1'b1;
                tlast <= (len_q == LSIZE'(1));
              end else begin
                state   <= GAP;
                gap_cnt <= '0;
                tvalid  <= 1'b0;
                tlast   <= 1'b0;
                tuser   <= 1'b0;
              end
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
              tuser    <= 1'b0;
              tlast    <= (LSIZE'(beat_cnt + 1'b1) == LSIZE'(len_q - 1'b1));
            end
          end
        end
        GAP: begin
          if (gap_cnt == GSIZE'(gap_q - 1'b1)) begin
            if (enable) begin
              state  <= SEND;
              tvalid <= 1'b1;
              tuser  <= 1'b1;
              tlast  <= (len_q == LSIZE'(1));
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign origin_inf.tvalid = tvalid;
  assign origin_inf.tdata  = tdata;
  assign origin_inf.tlast  = tlast;
  assign origin_inf.tuser  = tuser;

endmodule

// File: tb/tb_axis_pattern_gen.sv
// Bench for axis_pattern_gen: table of runs checked through an expected-beat queue,
// plus hand sequences for enable drop and mid-packet reset.
module tb_axis_pattern_gen;
  logic        clock = 1'b0;
  logic        rst, enable;
  logic [1:0]  mode;
  logic [15:0] seed, pkt_len, pkt_num;
  logic [7:0]  pkt_gap;
  logic        busy, done;
  logic [15:0] pkts_sent;

  always #5 clock = ~clock;

  axi_stream_inf #(.DSIZE(16), .USIZE(1)) origin_inf ();

  axis_pattern_gen #(.DSIZE(16), .LSIZE(16), .GSIZE(8), .CSIZE(16)) dut (
    .clock(clock), .rst(rst), .enable(enable), .mode(mode), .seed(seed),
    .pkt_len(pkt_len), .pkt_gap(pkt_gap), .pkt_num(pkt_num),
    .busy(busy), .done(done), .pkts_sent(pkts_sent), .origin_inf(origin_inf)
  );

  typedef struct {
    logic [15:0] data;
    logic        last;
    logic        user;
  } beat_t;

  typedef struct {
    string       name;
    logic [1:0]  mode;
    logic [15:0] seed;
    logic [15:0] len;
    logic [7:0]  gap;
    logic [15:0] num;
    int          rmode;
    logic [15:0] exp_first;
    int          exp_beats;
  } vec_t;

  beat_t       exp_q[$];
  int          checks = 0, failures = 0;
  int          rdy_mode = 0;
  bit          stall_prev = 0, rst_at_edge = 0;
  logic [17:0] held;
  int          hs_cnt = 0, done_cnt = 0, idle_cnt = 0, exp_gap = 0;
  logic [15:0] sent_at_done, first_data;
  bit          after_last = 0, first_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] model_lfsr_step(input logic [31:0] s);
    logic [31:0] n;
    n = {1'b0, s[31:1]};
    if (s[0]) begin
      n[31] = ~n[31]; n[21] = ~n[21]; n[1] = ~n[1]; n[0] = ~n[0];
    end
    return n;
  endfunction

  task automatic push_run(input logic [1:0] m, input logic [15:0] s, input logic [15:0] len,
                          input int npk);
    int          leff;
    logic [31:0] st;
    beat_t       b;
    leff = (len == 0) ? 1 : int'(len);
    st = {s, s};
    if (st == 32'd0) st = 32'd1;
    for (int i = 0; i < leff * npk; i++) begin
      case (m)
        2'd0:    b.data = s + 16'(i);
        2'd1:    b.data = st[15:0];
        2'd2:    b.data = s;
        default: b.data = 16'd1 << (i % 16);
      endcase
      b.last = ((i % leff) == leff - 1);
      b.user = ((i % leff) == 0);
      exp_q.push_back(b);
      st = model_lfsr_step(st);
    end
  endtask

  task automatic monitor();
    beat_t e;
    if (stall_prev && !rst_at_edge)
      check("stall_hold", {origin_inf.tvalid, origin_inf.tdata, origin_inf.tlast, origin_inf.tuser},
            {1'b1, held});
    if (done) begin
      done_cnt++;
      sent_at_done = pkts_sent;
    end
    if (origin_inf.tvalid) begin
      if (after_last) check("gap_len", idle_cnt, exp_gap);
      after_last = 0;
    end else if (after_last) begin
      idle_cnt++;
    end
    if (origin_inf.tvalid && origin_inf.tready) begin
      hs_cnt++;
      if (!first_seen) begin
        first_seen = 1;
        first_data = origin_inf.tdata;
      end
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {origin_inf.tdata, origin_inf.tlast, origin_inf.tuser}, 18'h0);
      end else begin
        e = exp_q.pop_front();
        check("beat", {origin_inf.tdata, origin_inf.tlast, origin_inf.tuser}, {e.data, e.last, e.user});
      end
      if (origin_inf.tlast) begin
        after_last = 1;
        idle_cnt = 0;
      end
    end
    stall_prev = origin_inf.tvalid && !origin_inf.tready;
    held = {origin_inf.tdata, origin_inf.tlast, origin_inf.tuser};
  endtask

  task automatic tick();
    rst_at_edge = rst;
    @(negedge clock);
    case (rdy_mode)
      0:       origin_inf.tready = 1'b1;
      1:       origin_inf.tready = 1'($urandom_range(0, 1));
      default: origin_inf.tready = 1'b0;
    endcase
    #1;
    monitor();
  endtask

  task automatic run_vec(input vec_t v);
    int  hs0;
    bit  got;
    mode = v.mode; seed = v.seed; pkt_len = v.len; pkt_gap = v.gap; pkt_num = v.num;
    rdy_mode = v.rmode;
    exp_gap = int'(v.gap);
    after_last = 0; first_seen = 0; done_cnt = 0; got = 0;
    hs0 = hs_cnt;
    push_run(v.mode, v.seed, v.len, int'(v.num));
    enable = 1'b1;
    tick();
    check({v.name, "_start_valid"}, {origin_inf.tvalid, busy}, 2'b11);
    // Scrambled config after the start must not affect the run in progress.
    seed = ~v.seed; mode = v.mode + 2'd1; pkt_len = 16'd7; pkt_gap = 8'd5; pkt_num = 16'd0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (done_cnt > 0) begin
        got = 1;
        break;
      end
    end
    enable = 1'b0;
    check({v.name, "_done_seen"}, got, 1'b1);
    check({v.name, "_sent_at_done"}, sent_at_done, v.num);
    after_last = 0;
    for (int i = 0; i < 4; i++) tick();
    check({v.name, "_done_once"}, done_cnt, 1);
    check({v.name, "_idle"}, {busy, origin_inf.tvalid}, 2'b00);
    check({v.name, "_queue_empty"}, exp_q.size(), 0);
    check({v.name, "_beats"}, hs_cnt - hs0, v.exp_beats);
    check({v.name, "_first"}, first_data, v.exp_first);
  endtask

  vec_t vecs[7];

  initial begin
    int hs0;
    vec_t rv;
    vecs[0] = '{"t1_incr",   2'd0, 16'h00F0, 16'd4,  8'd2, 16'd3, 0, 16'h00F0, 12};
    vecs[1] = '{"t2_stall",  2'd0, 16'h1234, 16'd5,  8'd0, 16'd6, 1, 16'h1234, 30};
    vecs[2] = '{"t3_prbs1",  2'd1, 16'h0001, 16'd8,  8'd1, 16'd2, 0, 16'h0001, 16};
    vecs[3] = '{"t3_prbs0",  2'd1, 16'h0000, 16'd4,  8'd0, 16'd2, 1, 16'h0001, 8};
    vecs[4] = '{"t4_walk",   2'd3, 16'h5555, 16'd20, 8'd0, 16'd1, 0, 16'h0001, 20};
    vecs[5] = '{"const",     2'd2, 16'hBEEF, 16'd3,  8'd1, 16'd2, 1, 16'hBEEF, 6};
    vecs[6] = '{"len0_wrap", 2'd0, 16'hFFFE, 16'd0,  8'd1, 16'd3, 0, 16'hFFFE, 3};

    rst = 1'b1; enable = 1'b0; mode = 2'd0; seed = '0; pkt_len = 16'd1; pkt_gap = '0; pkt_num = '0;
    origin_inf.tready = 1'b0;
    rdy_mode = 2;
    for (int i = 0; i < 3; i++) tick();
    check("rst_tvalid", origin_inf.tvalid, 1'b0);
    check("rst_tdata", origin_inf.tdata, 16'h0);
    check("rst_tlast_tuser", {origin_inf.tlast, origin_inf.tuser}, 2'b00);
    check("rst_busy_done", {busy, done}, 2'b00);
    check("rst_pkts_sent", pkts_sent, 16'h0);
    rst = 1'b0;
    tick(); tick();
    check("idle_no_enable", {busy, origin_inf.tvalid}, 2'b00);

    for (int k = 0; k < 7; k++) run_vec(vecs[k]);

    // Enable dropped during beat 3 of an unlimited run: packet finishes, no done.
    mode = 2'd0; seed = 16'h0100; pkt_len = 16'd8; pkt_gap = 8'd3; pkt_num = 16'd0;
    rdy_mode = 0; exp_gap = 3; after_last = 0; done_cnt = 0;
    hs0 = hs_cnt;
    push_run(2'd0, 16'h0100, 16'd8, 1);
    enable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (hs_cnt - hs0 >= 4) break;
    end
    enable = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (!busy) break;
    end
    after_last = 0;
    for (int i = 0; i < 6; i++) tick();
    check("t5_beats", hs_cnt - hs0, 8);
    check("t5_queue_empty", exp_q.size(), 0);
    check("t5_no_done", done_cnt, 0);
    check("t5_pkts_sent", pkts_sent, 16'd1);
    check("t5_idle", {busy, origin_inf.tvalid}, 2'b00);

    // Reset while a beat is stalled mid-packet, then restart from the seed.
    mode = 2'd0; seed = 16'h0A00; pkt_len = 16'd2; pkt_gap = 8'd0; pkt_num = 16'd0;
    rdy_mode = 0; exp_gap = 0; after_last = 0;
    hs0 = hs_cnt;
    push_run(2'd0, 16'h0A00, 16'd2, 2);
    enable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (hs_cnt - hs0 >= 3) break;
    end
    rdy_mode = 2;
    for (int i = 0; i < 3; i++) tick();
    check("t6_pre_rst_sent", pkts_sent, 16'd1);
    check("t6_pre_rst_stalled", {origin_inf.tvalid, origin_inf.tlast}, 2'b11);
    rst = 1'b1; enable = 1'b0;
    tick();
    check("t6_rst_state", {origin_inf.tvalid, busy, origin_inf.tlast, origin_inf.tuser}, 4'b0000);
    check("t6_rst_sent", pkts_sent, 16'd0);
    check("t6_leftover", exp_q.size(), 1);
    exp_q.delete();
    rst = 1'b0; after_last = 0;
    tick();
    rv = '{"t6_restart", 2'd0, 16'h0A00, 16'd2, 8'd0, 16'd1, 0, 16'h0A00, 2};
    run_vec(rv);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
